// File: rtl/fft_r2_ctrl_gen_if.sv
// Stream handshake bundle for the radix-2 FFT controller.
// master: controller side (drives in_ready, out_valid, out_bank); slave: source/sink side.
interface fft_r2_ctrl_gen_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic out_bank;

  modport master (
    input  in_valid, out_ready,
    output in_ready, out_valid, out_bank
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, out_valid, out_bank
  );
endinterface

// File: rtl/fft_r2_ctrl_gen.sv
// In-place radix-2 DIF FFT controller: LOAD, LOG2N butterfly stages with drain, UNLOAD.
// Ports: clk/rst, start/bitrev_out, io (in/out handshake), status, bank SRAM ctrl, butterfly ctrl.
module fft_r2_ctrl_gen #(
  parameter int LOG2N  = 6,
  parameter int BF_LAT = 2,
  localparam int AW    = LOG2N - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bitrev_out,
  fft_r2_ctrl_gen_if.master io,
  output logic              busy,
  output logic              done,
  output logic [3:0]        stage,
  output logic              we_b0,
  output logic              we_b1,
  output logic              re_b0,
  output logic              re_b1,
  output logic [AW-1:0]     waddr_b0,
  output logic [AW-1:0]     waddr_b1,
  output logic [AW-1:0]     raddr_b0,
  output logic [AW-1:0]     raddr_b1,
  output logic              swap_rd,
  output logic              swap_wr,
  output logic              bf_valid,
  output logic [AW-1:0]     tw_addr
);
  localparam int N  = 1 << LOG2N;
  localparam int H  = N / 2;
  localparam int D  = BF_LAT + 1;
  localparam int CW = LOG2N + 1;

  typedef logic [LOG2N-1:0] idx_t;
  typedef enum logic [2:0] {
    IDLE, LOAD, COMPUTE, DRAIN, UNLOAD
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt_q;
  idx_t          hcnt_q;
  logic [3:0]    s_q;
  logic [3:0]    dcnt_q;
  logic          brev_q;

  logic [D-1:0]  dl_v;
  logic [D-1:0]  dl_sr;
  logic [AW-1:0] dl_a0 [D];
  logic [AW-1:0] dl_a1 [D];

  function automatic idx_t rev(idx_t v);
    idx_t r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  idx_t          jm, k_i, span, lowm, top, oidx;
  logic [3:0]    p;
  logic [AW-1:0] a_top, a_bot, tw;
  logic          sr, klast, last_s, dr_end, jpar, ubank;
  logic          hs_in, hs_out, done_c, rd_c, u_iss;

  assign jm     = cnt_q[LOG2N-1:0];
  assign jpar   = ^jm;
  assign k_i    = idx_t'(cnt_q[AW-1:0]);
  // span = 1<<p; top = k with a zero inserted at bit p
  assign p      = 4'(LOG2N - 1) - s_q;
  assign span   = idx_t'(1) << p;
  assign lowm   = span - idx_t'(1);
  assign top    = ((k_i & ~lowm) << 1) | (k_i & lowm);
  assign sr     = ^top;
  assign a_top  = top[LOG2N-1:1];
  assign a_bot  = AW'((top | span) >> 1);
  assign tw     = AW'((k_i & lowm) << s_q);
  assign klast  = cnt_q[AW-1:0] == AW'(H - 1);
  assign last_s = s_q == 4'(LOG2N - 1);
  assign dr_end = dcnt_q == 4'(BF_LAT);

  assign oidx   = brev_q ? rev(jm) : jm;
  assign ubank  = ^oidx;

  assign rd_c   = state == COMPUTE;
  assign hs_in  = state == LOAD && io.in_valid && !rst;
  assign hs_out = state == UNLOAD && io.out_valid && io.out_ready;
  assign done_c = hs_out && hcnt_q == '1;
  // cnt_q[LOG2N] set means all N reads have been issued
  assign u_iss  = state == UNLOAD && !cnt_q[LOG2N]
               && (!io.out_valid || io.out_ready);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt         = state;
    busy        = state != IDLE;
    done        = done_c;
    stage       = (state == COMPUTE) ? s_q : 4'd0;
    io.in_ready = state == LOAD && !rst;
    we_b0       = 1'b0;
    we_b1       = 1'b0;
    re_b0       = 1'b0;
    re_b1       = 1'b0;
    waddr_b0    = '0;
    waddr_b1    = '0;
    raddr_b0    = '0;
    raddr_b1    = '0;
    swap_wr     = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: begin
        if (hs_in && jm == '1) nxt = COMPUTE;
        unique case (1'b1)
          !jpar: begin
            we_b0    = hs_in;
            waddr_b0 = jm[LOG2N-1:1];
          end
          jpar: begin
            we_b1    = hs_in;
            waddr_b1 = jm[LOG2N-1:1];
          end
        endcase
      end
      COMPUTE: begin
        if (klast) nxt = DRAIN;
        re_b0    = 1'b1;
        re_b1    = 1'b1;
        raddr_b0 = sr ? a_bot : a_top;
        raddr_b1 = sr ? a_top : a_bot;
      end
      DRAIN: if (dr_end) nxt = last_s ? UNLOAD : COMPUTE;
      UNLOAD: begin
        if (done_c) nxt = IDLE;
        re_b0 = u_iss && !ubank;
        re_b1 = u_iss && ubank;
        if (ubank) raddr_b1 = oidx[LOG2N-1:1];
        else       raddr_b0 = oidx[LOG2N-1:1];
      end
      default: nxt = IDLE;
    endcase
    if (dl_v[D-1] && !rst) begin
      we_b0    = 1'b1;
      we_b1    = 1'b1;
      waddr_b0 = dl_a0[D-1];
      waddr_b1 = dl_a1[D-1];
      swap_wr  = dl_sr[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hcnt_q <= '0;
      s_q    <= '0;
      dcnt_q <= '0;
      brev_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          cnt_q  <= '0;
          hcnt_q <= '0;
          s_q    <= '0;
          dcnt_q <= '0;
          brev_q <= bitrev_out;
        end
        LOAD: if (hs_in) cnt_q <= (jm == '1) ? '0 : cnt_q + CW'(1);
        COMPUTE: cnt_q <= klast ? '0 : cnt_q + CW'(1);
        DRAIN: begin
          if (dr_end) begin
            dcnt_q <= '0;
            s_q    <= last_s ? 4'd0 : s_q + 4'd1;
          end else begin
            dcnt_q <= dcnt_q + 4'd1;
          end
        end
        UNLOAD: begin
          if (u_iss)  cnt_q  <= cnt_q + CW'(1);
          if (hs_out) hcnt_q <= done_c ? '0 : hcnt_q + LOG2N'(1);
          if (done_c) cnt_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  // read-side alignment regs and write-back delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      bf_valid     <= 1'b0;
      swap_rd      <= 1'b0;
      tw_addr      <= '0;
      dl_v         <= '0;
      dl_sr        <= '0;
      io.out_valid <= 1'b0;
      io.out_bank  <= 1'b0;
      for (int i = 0; i < D; i++) begin
        dl_a0[i] <= '0;
        dl_a1[i] <= '0;
      end
    end else begin
      bf_valid <= rd_c;
      swap_rd  <= rd_c && sr;
      tw_addr  <= rd_c ? tw : '0;
      dl_v[0]  <= rd_c;
      dl_sr[0] <= rd_c && sr;
      dl_a0[0] <= sr ? a_bot : a_top;
      dl_a1[0] <= sr ? a_top : a_bot;
      for (int i = 1; i < D; i++) begin
        dl_v[i]  <= dl_v[i-1];
        dl_sr[i] <= dl_sr[i-1];
        dl_a0[i] <= dl_a0[i-1];
        dl_a1[i] <= dl_a1[i-1];
      end
      if (!io.out_valid || io.out_ready) begin
        io.out_valid <= u_iss;
        io.out_bank  <= u_iss && ubank;
      end
    end
  end
endmodule

// File: tb/tb_fft_r2_ctrl_gen.sv
// Directed bench for fft_r2_ctrl_gen: N=64/BF_LAT=2 instance plus N=8/BF_LAT=0 latency instance.
// Ports of both DUTs driven from one linear initial block; a negedge monitor tracks hazards/unload order.
module tb_fft_r2_ctrl_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, bitrev_out = 1'b0;
  logic       busy, done, we_b0, we_b1, re_b0, re_b1;
  logic       swap_rd, swap_wr, bf_valid;
  logic [3:0] stage;
  logic [4:0] waddr_b0, waddr_b1, raddr_b0, raddr_b1, tw_addr;

  logic       start1 = 1'b0, bitrev1 = 1'b0;
  logic       busy1, done1, we1_b0, we1_b1, re1_b0, re1_b1;
  logic       swap1_rd, swap1_wr, bf1_valid;
  logic [3:0] stage1;
  logic [1:0] w1a0, w1a1, r1a0, r1a1, tw1;

  fft_r2_ctrl_gen_if io0 ();
  fft_r2_ctrl_gen_if io1 ();

  fft_r2_ctrl_gen #(.LOG2N(6), .BF_LAT(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .bitrev_out(bitrev_out),
    .io(io0), .busy(busy), .done(done), .stage(stage),
    .we_b0(we_b0), .we_b1(we_b1), .re_b0(re_b0), .re_b1(re_b1),
    .waddr_b0(waddr_b0), .waddr_b1(waddr_b1),
    .raddr_b0(raddr_b0), .raddr_b1(raddr_b1),
    .swap_rd(swap_rd), .swap_wr(swap_wr), .bf_valid(bf_valid),
    .tw_addr(tw_addr)
  );

  fft_r2_ctrl_gen #(.LOG2N(3), .BF_LAT(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bitrev_out(bitrev1),
    .io(io1), .busy(busy1), .done(done1), .stage(stage1),
    .we_b0(we1_b0), .we_b1(we1_b1), .re_b0(re1_b0), .re_b1(re1_b1),
    .waddr_b0(w1a0), .waddr_b1(w1a1), .raddr_b0(r1a0), .raddr_b1(r1a1),
    .swap_rd(swap1_rd), .swap_wr(swap1_wr), .bf_valid(bf1_valid),
    .tw_addr(tw1)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] brev6(logic [5:0] v);
    return {v[0], v[1], v[2], v[3], v[4], v[5]};
  endfunction

  int         pend0 [32] = '{default: 0};
  int         pend1 [32] = '{default: 0};
  int         hazards = 0, hs = 0, order_bad = 0, ndone = 0, done_hs = 0;
  logic [5:0] last_idx = '0;
  logic [5:0] seq [64] = '{default: '0};
  bit         seen [64] = '{default: 1'b0};

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        pend0[i] = 0;
        pend1[i] = 0;
      end
    end else begin
      if (re_b0 && re_b1 && (pend0[raddr_b0] != 0 || pend1[raddr_b1] != 0))
        hazards++;
      if (we_b0 && we_b1) begin
        pend0[waddr_b0]--;
        pend1[waddr_b1]--;
      end
      if (re_b0 && re_b1) begin
        pend0[raddr_b0]++;
        pend1[raddr_b1]++;
      end
      if (io0.out_valid && io0.out_ready) begin
        if (hs < 64) seq[hs] = last_idx;
        if (last_idx != brev6(6'(hs))) order_bad++;
        if (io0.out_bank !== ^last_idx) order_bad++;
        seen[last_idx] = 1'b1;
        hs++;
        if (done) done_hs = hs;
      end
      if (done) ndone++;
      if (re_b0 ^ re_b1)
        last_idx = re_b0 ? {raddr_b0, ^raddr_b0} : {raddr_b1, ~^raddr_b1};
    end
  end

  initial begin
    int j, c, nwr, bad, dr, n, uniq;
    io0.in_valid = 1'b0; io0.out_ready = 1'b0;
    io1.in_valid = 1'b0; io1.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", io0.in_ready, 0);
    chk("rst_we", {we_b0, we_b1}, 0);
    chk("rst_out_valid", io0.out_valid, 0);

    // mid-LOAD reset at j=17
    start = 1'b1; bitrev_out = 1'b1; io0.in_valid = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("load_in_ready", io0.in_ready, 1);
    chk("load_j0_we", {we_b0, we_b1}, 2'b10);
    repeat (17) tick();
    rst = 1'b1;
    #1;
    chk("rst_cycle_we", {we_b0, we_b1}, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst2_busy", busy, 0);
    chk("rst2_in_ready", io0.in_ready, 0);
    chk("rst2_we_re", {we_b0, we_b1, re_b0, re_b1}, 0);
    chk("rst2_misc", {bf_valid, swap_rd, swap_wr, done, stage, tw_addr}, 0);

    // restart, load 64 samples with a gap every 3rd cycle
    start = 1'b1;
    tick();
    start = 1'b0; bitrev_out = 1'b0;
    j = 0; c = 0; nwr = 0;
    while (j < 64 && c < 300) begin
      io0.in_valid = (c % 3 != 2);
      #1;
      if (we_b0 || we_b1) nwr++;
      if (io0.in_valid && j == 0)
        chk("restart_j0", {we_b0, we_b1, waddr_b0}, {2'b10, 5'd0});
      if (io0.in_valid && j == 5)
        chk("sample5", {we_b0, we_b1, waddr_b0}, {2'b10, 5'd2});
      if (io0.in_valid && j == 7)
        chk("sample7", {we_b0, we_b1, waddr_b1}, {2'b01, 5'd3});
      if (io0.in_valid) j++;
      c++;
      tick();
    end
    io0.in_valid = 1'b0;
    #1;
    chk("load_count", j, 64);
    chk("load_writes", nwr, 64);
    chk("in_ready_after", io0.in_ready, 0);

    // stage 0 butterflies
    chk("s0k0_raddr", {re_b0, re_b1, raddr_b0, raddr_b1}, {2'b11, 5'd0, 5'd16});
    chk("s0k0_bfv", bf_valid, 0);
    tick(); #1;
    chk("s0k1_raddr", {raddr_b0, raddr_b1}, {5'd16, 5'd0});
    chk("s0k0_bf", {bf_valid, swap_rd, tw_addr}, {2'b10, 5'd0});
    tick(); #1;
    chk("s0k1_bf", {bf_valid, swap_rd, tw_addr}, {2'b11, 5'd1});
    tick(); #1;
    chk("s0k0_wr", {we_b0, we_b1, swap_wr, waddr_b0, waddr_b1},
        {3'b110, 5'd0, 5'd16});

    // stage 5
    c = 0;
    while (stage != 4'd5 && c < 400) begin
      tick(); #1;
      c++;
    end
    chk("s5_reached", stage, 5);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (raddr_b0 !== 5'(k) || raddr_b1 !== 5'(k) || !re_b0 || !re_b1) bad++;
      if (bf_valid && tw_addr !== 5'd0) bad++;
      tick(); #1;
    end
    chk("s5_addr_tw", bad, 0);
    chk("drain_stage_busy", {busy, stage}, {1'b1, 4'd0});
    dr = 0;
    while (!re_b0 && !re_b1 && dr < 10) begin
      dr++;
      if (dr == 3)
        chk("s5k31_wr", {we_b0, we_b1, swap_wr, waddr_b0, waddr_b1},
            {3'b111, 5'd31, 5'd31});
      tick(); #1;
    end
    chk("drain_len", dr, 3);

    // unload with out_ready toggling every cycle
    c = 0;
    while (busy && c < 400) begin
      io0.out_ready = ~io0.out_ready;
      tick();
      c++;
    end
    io0.out_ready = 1'b0;
    #1;
    chk("unload_end_busy", busy, 0);
    chk("unload_hs", hs, 64);
    chk("unload_order", order_bad, 0);
    chk("seq1", seq[1], 32);
    chk("seq2", seq[2], 16);
    chk("seq3", seq[3], 48);
    chk("seq63", seq[63], 63);
    uniq = 0;
    for (int i = 0; i < 64; i++) if (seen[i]) uniq++;
    chk("unload_unique", uniq, 64);
    chk("done_count", ndone, 1);
    chk("done_at_hs", done_hs, 64);
    chk("raw_hazard", hazards, 0);

    // N=8, BF_LAT=0 latency; done expected in cycle 32 after start edge
    start1 = 1'b1; io1.in_valid = 1'b1; io1.out_ready = 1'b1;
    tick();
    start1 = 1'b0;
    #1;
    n = 0;
    while (!done1 && n < 200) begin
      tick(); #1;
      n++;
    end
    chk("n8_latency", n + 1, 32);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    #1;
    chk("n8_start_in_done", busy1, 0);
    chk("n8_done_pulse", done1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fft_r2_ctrl_gen.md
Name: fft_r2_ctrl_gen

Overview:
- Parametrised control FSM for an in-place radix-2 DIF FFT.
- Data lives in two single-word dual-port SRAM banks of N/2 words each. Sample index i maps to bank parity(i) (XOR of all bits of i), at word address i>>1.
- Sequences LOAD (ready/valid input), LOG2N butterfly stages with pipeline drain between stages, and UNLOAD (ready/valid output, natural or bit-reversed order).
- Drives SRAM enables/addresses, butterfly crossbar swaps and twiddle ROM address; the datapath is separate.

Parameters:
- LOG2N, 6, log2 of FFT length N (3..10).
- BF_LAT, 2, butterfly pipeline latency in cycles (0..8), from operands-valid to results-valid.
- AW, LOG2N-1, bank address width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a frame; honoured only in IDLE
- bitrev_out  in  1  sampled at start; 1 = unload in natural frequency order, 0 = raw memory order
- in_valid  in  1  input sample present
- in_ready  out  1  controller accepts input sample (LOAD only)
- out_ready  in  1  downstream accepts output sample
- out_valid  out  1  output sample on bank read data
- out_bank  out  1  bank select for output mux, aligned with out_valid
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse on the final output handshake
- stage  out  4  current stage number 0..LOG2N-1, 0 outside COMPUTE
- we_b0, we_b1, re_b0, re_b1  out  1 each  bank write/read enables
- waddr_b0, waddr_b1, raddr_b0, raddr_b1  out  AW each  bank addresses
- swap_rd  out  1  1 = top operand is on bank1 read data; aligned with bf_valid
- swap_wr  out  1  1 = top result is written to bank1; aligned with write enables
- bf_valid  out  1  operands valid at butterfly input
- tw_addr  out  LOG2N-1  twiddle index, aligned with bf_valid

Behaviour:
- Reset: state IDLE; all outputs 0; all counters and delay lines cleared. rst mid-frame returns to IDLE at the next edge. No write enable is asserted in the reset cycle or after it. Pending delayed writes are discarded.
- States and transitions:
  - IDLE -> LOAD on start. bitrev_out is latched on that edge.
  - LOAD -> COMPUTE after N accepted samples.
  - COMPUTE -> DRAIN after the last of the N/2 butterfly reads in the stage.
  - DRAIN lasts BF_LAT+1 cycles. Then stage+1 -> COMPUTE, or UNLOAD after stage LOG2N-1.
  - UNLOAD -> IDLE after N output handshakes.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready with sample counter j: bank parity(j) is written at address j>>1.
  - Only that bank's we is 1, combinationally.
  - j increments only on a handshake; in_valid gaps stall it.
- COMPUTE stage s, butterfly k=0..N/2-1, one per cycle, no stalls:
  - span = N>>(s+1).
  - top = k with a 0 bit inserted at bit position LOG2N-1-s; bottom = top+span.
  - top and bottom always fall in opposite banks.
  - re_b0=re_b1=1. Each bank reads the address (>>1) of whichever of top/bottom it holds.
  - sr = parity(top).
  - tw_addr = (k mod span) << s.
- Write-back:
  - swap_rd and tw_addr (from k) are registered 1 cycle; bf_valid is the registered read-issue flag, so all three are valid 1 cycle after the read.
  - Addresses and sr are delayed BF_LAT+1 cycles from read issue. They appear on waddr_b*, swap_wr and we_b0=we_b1=1.
  - Writes of stage s complete in the last DRAIN cycle. The first read of stage s+1 is issued the following cycle, so there is no read-after-write hazard.
- UNLOAD:
  - Output order m=0..N-1. Index = bitrev(m) if bitrev_out else m.
  - Only bank parity(index) is read, at index>>1.
  - Read issue is allowed when !out_valid || out_ready. out_valid is registered from the issue flag. out_bank is registered bank.
  - With out_ready low, no re is issued, and the SRAM output holds.
  - done pulses with the handshake of m=N-1.
- Stage cycles: N/2 + BF_LAT + 1. A full frame with no stalls takes N + LOG2N*(N/2+BF_LAT+1) + N + 1 cycles to done.
- start during busy is ignored. A start in the done cycle is ignored; the block must be in IDLE first.
- Counters wrap only via state transitions; no arithmetic overflow is reachable.

Test Plan:
1. Reset with rst=1 for 2 cycles mid-LOAD at j=17 -> next cycle all outputs 0, busy=0. A following start restarts at j=0, writing bank0 address 0.
2. Defaults; feed 64 samples with in_valid low every 3rd cycle -> exactly 64 writes. Sample 5 goes to bank0 address 2; sample 7 goes to bank1 address 3. in_ready=0 after the 64th.
3. Stage 0:
   - k=0 -> raddr_b0=0, raddr_b1=16, swap_rd=0.
   - k=1 -> raddr_b1=0, raddr_b0=16, swap_rd=1.
   - tw_addr=0 then 1.
   - Writes for k=0 occur 3 cycles after its read, with identical addresses.
4. Stage 5 -> butterfly k reads word k on both banks, tw_addr=0 always. DRAIN lasts 3 cycles. No read overlaps a pending write to the same address.
5. Fill memory with an impulse at index 0, run with bitrev_out=1 and out_ready toggling every cycle -> 64 handshakes, no duplicated or skipped index. done pulses once.
6. LOG2N=3, BF_LAT=0, no stalls -> done 8 + 3*5 + 8 + 1 = 32 cycles after start.
